// File: rtl/sram_port_arbiter_pkg.sv
// rtl/sram_port_arbiter_pkg.sv - shared types and default geometry for the SRAM port arbiter
package sram_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DEPTH_DEF  = 64;
    localparam int DATA_W_DEF = 50;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/rsp_fifo2.sv
// rtl/rsp_fifo2.sv - two-entry response FIFO with occupancy output
module rsp_fifo2 #(
    parameter int DATA_W = 50
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;
    logic              w_push;
    logic              w_pop;

    assign w_pop  = i_pop & (r_count != 2'd0);
    assign w_push = i_push & ((r_count != 2'd2) | w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_push_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_data  = o_valid ? r_mem[r_rptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - round-robin sharing of one single-port SRAM between two requesters
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              ram_en,
    output logic              ram_wmode,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              init_done
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_init_cnt;
    req_id_t           r_prio;
    logic              r_rd_vld;
    req_id_t           r_rd_id;

    logic [1:0]        w_cnt0;
    logic [1:0]        w_cnt1;
    logic              w_pop0;
    logic              w_pop1;
    logic [2:0]        w_occ0;
    logic [2:0]        w_occ1;
    logic [2:0]        w_credit0;
    logic [2:0]        w_credit1;
    logic              w_elig0;
    logic              w_elig1;
    logic              w_gnt0;
    logic              w_gnt1;

    assign w_pop0 = rsp0_valid & rsp0_ready;
    assign w_pop1 = rsp1_valid & rsp1_ready;

    // A pop this cycle frees its slot for a read granted this cycle, giving one read per cycle.
    assign w_occ0    = {1'b0, w_cnt0} + {2'b00, r_rd_vld & (r_rd_id == 1'b0)};
    assign w_occ1    = {1'b0, w_cnt1} + {2'b00, r_rd_vld & (r_rd_id == 1'b1)};
    assign w_credit0 = 3'd2 - w_occ0 + {2'b00, w_pop0};
    assign w_credit1 = 3'd2 - w_occ1 + {2'b00, w_pop1};

    assign w_elig0 = (r_state == ST_RUN) & req0_valid & (req0_write | (w_credit0 != 3'd0));
    assign w_elig1 = (r_state == ST_RUN) & req1_valid & (req1_write | (w_credit1 != 3'd0));

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_elig0 && w_elig1) begin
            w_gnt0 = (r_prio == 1'b0);
            w_gnt1 = (r_prio == 1'b1);
        end else begin
            w_gnt0 = w_elig0;
            w_gnt1 = w_elig1;
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign init_done  = (r_state == ST_RUN);

    // Clear outputs are qualified by reset_n so the RAM port stays idle while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        ram_en      = 1'b0;
        ram_wmode   = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;
        case (r_state)
            ST_INIT: begin
                if (INIT_CLEAR) begin
                    ram_en    = reset_n;
                    ram_wmode = reset_n;
                    ram_addr  = r_init_cnt;
                    if (r_init_cnt == ADDR_W'(DEPTH - 1)) begin
                        w_state_nxt = ST_RUN;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_gnt0) begin
                    ram_en    = 1'b1;
                    ram_wmode = req0_write;
                    ram_addr  = req0_addr;
                    ram_wdata = req0_wdata;
                end else if (w_gnt1) begin
                    ram_en    = 1'b1;
                    ram_wmode = req1_write;
                    ram_addr  = req1_addr;
                    ram_wdata = req1_wdata;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_prio     <= 1'b0;
            r_rd_vld   <= 1'b0;
            r_rd_id    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + 1'b1;
            end
            if (w_gnt0 || w_gnt1) begin
                r_prio <= w_gnt0;
            end
            r_rd_vld <= (w_gnt0 & ~req0_write) | (w_gnt1 & ~req1_write);
            r_rd_id  <= w_gnt1;
        end
    end

    rsp_fifo2 #(.DATA_W(DATA_W)) u_rsp_fifo0 (
        .i_clk       (clock),
        .i_rst_n     (reset_n),
        .i_push      (r_rd_vld & (r_rd_id == 1'b0)),
        .i_push_data (ram_rdata),
        .i_pop       (rsp0_ready),
        .o_valid     (rsp0_valid),
        .o_data      (rsp0_rdata),
        .o_count     (w_cnt0)
    );

    rsp_fifo2 #(.DATA_W(DATA_W)) u_rsp_fifo1 (
        .i_clk       (clock),
        .i_rst_n     (reset_n),
        .i_push      (r_rd_vld & (r_rd_id == 1'b1)),
        .i_push_data (ram_rdata),
        .i_pop       (rsp1_ready),
        .o_valid     (rsp1_valid),
        .o_data      (rsp1_rdata),
        .o_count     (w_cnt1)
    );

    a_credit0_bounds: assert property (@(posedge clock) disable iff (!reset_n)
        (w_occ0 <= 3'd2) && (w_credit0 <= 3'd2));
    a_credit1_bounds: assert property (@(posedge clock) disable iff (!reset_n)
        (w_occ1 <= 3'd2) && (w_credit1 <= 3'd2));

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - scoreboard bench for sram_port_arbiter
module tb_sram_port_arbiter;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
    localparam int DATA_W = 50;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              req0_valid, req0_ready, req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid, rsp0_ready;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              req1_valid, req1_ready, req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid, rsp1_ready;
    logic [DATA_W-1:0] rsp1_rdata;
    logic              ram_en, ram_wmode;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              init_done;

    always #5 clock = ~clock;

    sram_port_arbiter #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W), .INIT_CLEAR(1'b1)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(rsp1_rdata),
        .ram_en(ram_en), .ram_wmode(ram_wmode), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .init_done(init_done)
    );

    // Single-port SRAM macro model with registered read data.
    logic [DATA_W-1:0] ram_mem [DEPTH];
    initial begin
        ram_rdata = '0;
        for (int i = 0; i < DEPTH; i++) ram_mem[i] = DATA_W'({$urandom, $urandom}) | DATA_W'(1);
    end
    always @(posedge clock) begin
        if (ram_en) begin
            if (ram_wmode) ram_mem[ram_addr] <= ram_wdata;
            else           ram_rdata <= ram_mem[ram_addr];
        end
    end

    logic [DATA_W-1:0] shadow [DEPTH];
    logic [DATA_W-1:0] exp0 [$];
    logic [DATA_W-1:0] exp1 [$];
    logic [DATA_W-1:0] e0, e1;
    int total = 0;
    int bad = 0;
    int n_rsp0 = 0;
    int n_rsp1 = 0;

    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            if (rsp0_valid && rsp0_ready) begin
                total++;
                n_rsp0++;
                if (exp0.size() == 0) begin
                    bad++;
                    $display("FAIL rsp0_unexpected got=%h required=none", rsp0_rdata);
                end else begin
                    e0 = exp0.pop_front();
                    if (rsp0_rdata !== e0) begin
                        bad++;
                        $display("FAIL rsp0_data got=%h required=%h", rsp0_rdata, e0);
                    end
                end
            end
            if (rsp1_valid && rsp1_ready) begin
                total++;
                n_rsp1++;
                if (exp1.size() == 0) begin
                    bad++;
                    $display("FAIL rsp1_unexpected got=%h required=none", rsp1_rdata);
                end else begin
                    e1 = exp1.pop_front();
                    if (rsp1_rdata !== e1) begin
                        bad++;
                        $display("FAIL rsp1_data got=%h required=%h", rsp1_rdata, e1);
                    end
                end
            end
            if (req0_valid && req0_ready) begin
                if (req0_write) shadow[req0_addr] = req0_wdata;
                else            exp0.push_back(shadow[req0_addr]);
            end
            if (req1_valid && req1_ready) begin
                if (req1_write) shadow[req1_addr] = req1_wdata;
                else            exp1.push_back(shadow[req1_addr]);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        int good_wr;
        int early_rdy;
        reset_n = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 6'd10; req0_wdata = 50'h1_2345_6789_ABCD;
        repeat (3) @(posedge clock);
        @(negedge clock);
        total++;
        if ({init_done, req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b required=00000",
                     {init_done, req0_ready, req1_ready, rsp0_valid, rsp1_valid});
        end
        total++;
        if (rsp0_rdata !== '0 || rsp1_rdata !== '0) begin
            bad++;
            $display("FAIL reset_rdata got=%h/%h required=0/0", rsp0_rdata, rsp1_rdata);
        end
        total++;
        if (ram_en !== 1'b0 || ram_wmode !== 1'b0 || ram_addr !== '0 || ram_wdata !== '0) begin
            bad++;
            $display("FAIL reset_ram got=%b%b %h %h required=00 0 0", ram_en, ram_wmode, ram_addr, ram_wdata);
        end
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        exp0.delete(); exp1.delete();
        tick();
        reset_n = 1'b1;
        good_wr = 0;
        early_rdy = 0;
        for (int c = 0; c < DEPTH; c++) begin
            @(negedge clock);
            if (ram_en === 1'b1 && ram_wmode === 1'b1 && ram_addr === ADDR_W'(c) &&
                ram_wdata === '0 && init_done === 1'b0) good_wr++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) early_rdy++;
            tick();
        end
        total++;
        if (good_wr !== DEPTH) begin
            bad++;
            $display("FAIL init_writes got=%0d required=%0d", good_wr, DEPTH);
        end
        total++;
        if (early_rdy !== 0) begin
            bad++;
            $display("FAIL init_ready got=%0d required=0", early_rdy);
        end
        @(negedge clock);
        total++;
        if (init_done !== 1'b1) begin
            bad++;
            $display("FAIL init_done_cycle65 got=%b required=1", init_done);
        end
        total++;
        if (req0_ready !== 1'b1 || ram_en !== 1'b1 || ram_wmode !== 1'b1 || ram_addr !== 6'd10) begin
            bad++;
            $display("FAIL first_grant got=%b%b%b %0d required=111 10", req0_ready, ram_en, ram_wmode, ram_addr);
        end
        tick();
        req0_valid = 1'b0;
    endtask

    task automatic test_write_read();
        logic [DATA_W-1:0] v;
        bit got;
        v = 50'h2_AAAA_5555_1234;
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 6'd5; req0_wdata = v;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clock);
            got = req0_ready;
            tick();
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL wr_grant got=timeout required=grant");
        end
        req0_write = 1'b0;
        @(negedge clock);
        total++;
        if (req0_ready !== 1'b1) begin
            bad++;
            $display("FAIL rd_grant got=%b required=1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        @(negedge clock);
        total++;
        if (rsp0_valid !== 1'b0) begin
            bad++;
            $display("FAIL rsp_early got=%b required=0", rsp0_valid);
        end
        tick();
        @(negedge clock);
        total++;
        if (rsp0_valid !== 1'b1 || rsp0_rdata !== v) begin
            bad++;
            $display("FAIL rsp_latency got=%b %h required=1 %h", rsp0_valid, rsp0_rdata, v);
        end
        tick();
        @(negedge clock);
        total++;
        if (ram_en !== 1'b0 || ram_addr !== '0 || ram_wdata !== '0) begin
            bad++;
            $display("FAIL idle_ram got=%b %h %h required=0 0 0", ram_en, ram_addr, ram_wdata);
        end
        tick();
    endtask

    task automatic test_contention();
        int g0, g1, sw, dbl, prev, cur;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 6'd1; req0_wdata = 50'h1_0101_0101_0101;
        req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 6'd2; req1_wdata = 50'h2_0202_0202_0202;
        for (int k = 0; k < 10 && (req0_valid || req1_valid); k++) begin
            @(negedge clock);
            cur = req0_ready ? 0 : (req1_ready ? 1 : -1);
            tick();
            if (cur == 0) req0_valid = 1'b0;
            if (cur == 1) req1_valid = 1'b0;
        end
        total++;
        if (req0_valid || req1_valid) begin
            bad++;
            $display("FAIL cont_writes got=%b%b required=00", req0_valid, req1_valid);
        end
        req0_write = 1'b0; req1_write = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        g0 = 0; g1 = 0; sw = 0; dbl = 0; prev = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (req0_ready && req1_ready) dbl++;
            cur = req0_ready ? 0 : (req1_ready ? 1 : -1);
            if (cur == 0) g0++;
            if (cur == 1) g1++;
            if (cur != -1 && prev != -1 && cur != prev) sw++;
            if (cur != -1) prev = cur;
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        total++;
        if (g0 !== 4 || g1 !== 4 || dbl !== 0) begin
            bad++;
            $display("FAIL cont_grants got=%0d/%0d dbl=%0d required=4/4 dbl=0", g0, g1, dbl);
        end
        total++;
        if (sw !== 7) begin
            bad++;
            $display("FAIL cont_alternate got=%0d required=7", sw);
        end
        repeat (5) tick();
        total++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            bad++;
            $display("FAIL cont_drain got=%0d/%0d required=0/0", exp0.size(), exp1.size());
        end
    endtask

    task automatic test_backpressure();
        int tmo, acc, idx, rsp_base;
        bit got;
        rsp1_ready = 1'b0;
        tmo = 0;
        for (int a = 0; a < 4; a++) begin
            req1_valid = 1'b1; req1_write = 1'b1;
            req1_addr = ADDR_W'(20 + a);
            req1_wdata = 50'h3_1111_0000_0000 | DATA_W'(a + 1);
            got = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                @(negedge clock);
                got = req1_ready;
                tick();
            end
            if (!got) tmo++;
        end
        total++;
        if (tmo !== 0) begin
            bad++;
            $display("FAIL bp_setup got=%0d required=0", tmo);
        end
        rsp_base = n_rsp1;
        req1_write = 1'b0;
        idx = 0;
        acc = 0;
        req1_addr = 6'd20;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            got = req1_ready;
            tick();
            if (got) begin
                acc++;
                idx++;
                req1_addr = ADDR_W'(20 + idx);
            end
        end
        total++;
        if (acc !== 2) begin
            bad++;
            $display("FAIL bp_accepted got=%0d required=2", acc);
        end
        @(negedge clock);
        total++;
        if (rsp1_valid !== 1'b1 || rsp1_rdata !== 50'h3_1111_0000_0001) begin
            bad++;
            $display("FAIL bp_head got=%b %h required=1 3111100000001", rsp1_valid, rsp1_rdata);
        end
        tick();
        req1_write = 1'b1; req1_addr = 6'd30; req1_wdata = 50'h0_3030_3030_3030;
        @(negedge clock);
        total++;
        if (req1_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_write got=%b required=1", req1_ready);
        end
        tick();
        req1_write = 1'b0;
        req1_addr = ADDR_W'(20 + idx);
        rsp1_ready = 1'b1;
        for (int c = 0; c < 12 && idx < 4; c++) begin
            @(negedge clock);
            got = req1_ready;
            tick();
            if (got) begin
                idx++;
                req1_addr = ADDR_W'(20 + idx);
            end
        end
        req1_valid = 1'b0;
        total++;
        if (idx !== 4) begin
            bad++;
            $display("FAIL bp_resume got=%0d required=4", idx);
        end
        repeat (5) tick();
        total++;
        if (exp1.size() != 0 || (n_rsp1 - rsp_base) !== 4) begin
            bad++;
            $display("FAIL bp_drain got=%0d left=%0d required=4 left=0", n_rsp1 - rsp_base, exp1.size());
        end
    endtask

    task automatic test_reset_mid();
        int acc, stale;
        bit got;
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 6'd5;
        acc = 0;
        for (int c = 0; c < 8 && acc < 2; c++) begin
            @(negedge clock);
            got = req0_ready;
            tick();
            if (got) begin
                acc++;
                req0_addr = 6'd10;
            end
        end
        req0_valid = 1'b0;
        total++;
        if (acc !== 2) begin
            bad++;
            $display("FAIL mid_setup got=%0d required=2", acc);
        end
        #1;
        reset_n = 1'b0;
        exp0.delete(); exp1.delete();
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        #1;
        total++;
        if (rsp0_valid !== 1'b0 || init_done !== 1'b0 || ram_en !== 1'b0) begin
            bad++;
            $display("FAIL mid_async got=%b%b%b required=000", rsp0_valid, init_done, ram_en);
        end
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        total++;
        if (ram_en !== 1'b1 || ram_wmode !== 1'b1 || ram_addr !== '0) begin
            bad++;
            $display("FAIL mid_restart got=%b%b %0d required=11 0", ram_en, ram_wmode, ram_addr);
        end
        stale = 0;
        for (int c = 0; c < DEPTH; c++) begin
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) stale++;
            tick();
            @(negedge clock);
        end
        total++;
        if (stale !== 0) begin
            bad++;
            $display("FAIL mid_stale got=%0d required=0", stale);
        end
        total++;
        if (init_done !== 1'b1) begin
            bad++;
            $display("FAIL mid_init_done got=%b required=1", init_done);
        end
        tick();
        rsp0_ready = 1'b1;
    endtask

    task automatic test_readback();
        logic [ADDR_W-1:0] addrs [4];
        int tmo, rsp_base;
        bit got;
        addrs[0] = 6'd0; addrs[1] = 6'd31; addrs[2] = 6'd63; addrs[3] = 6'd5;
        rsp0_ready = 1'b1;
        rsp_base = n_rsp0;
        tmo = 0;
        for (int a = 0; a < 4; a++) begin
            req0_valid = 1'b1; req0_write = 1'b0; req0_addr = addrs[a];
            got = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                @(negedge clock);
                got = req0_ready;
                tick();
            end
            if (!got) tmo++;
        end
        req0_valid = 1'b0;
        repeat (4) tick();
        total++;
        if (tmo !== 0 || exp0.size() != 0 || (n_rsp0 - rsp_base) !== 4) begin
            bad++;
            $display("FAIL readback got=tmo%0d rsp%0d left%0d required=tmo0 rsp4 left0",
                     tmo, n_rsp0 - rsp_base, exp0.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_readback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one single-port, 64-entry × 50-bit synchronous SRAM macro (shared enable, write-mode select, one-cycle registered-address read) between two independent requesters. Each requester gets a valid/ready request channel and a valid/ready read-response channel. The block handles round-robin arbitration, read-response return with per-requester credit flow control, and a post-reset clear of the whole array. It sits between the SRAM macro instance and the two pipeline clients that read and update that table.

## Interface
Parameters:
- ADDR_W, 6, SRAM address width
- DEPTH, 64, SRAM entries; equals 2^ADDR_W
- DATA_W, 50, SRAM word width
- INIT_CLEAR, 1, when 1, write zero to every entry after reset before accepting requests

Ports (i ∈ {0,1}):
- clock  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req{i}_valid  in  1  request present
- req{i}_ready  out  1  request accepted this cycle when high with valid
- req{i}_write  in  1  1 = write, 0 = read
- req{i}_addr  in  ADDR_W  entry index
- req{i}_wdata  in  DATA_W  write data
- rsp{i}_valid  out  1  read data available
- rsp{i}_ready  in  1  requester consumes response
- rsp{i}_rdata  out  DATA_W  read data
- ram_en  out  1  SRAM enable
- ram_wmode  out  1  SRAM write select
- ram_addr  out  ADDR_W  SRAM address
- ram_wdata  out  DATA_W  SRAM write data
- ram_rdata  in  DATA_W  SRAM read data, valid the cycle after a read issue
- init_done  out  1  high once the clear sequence has finished; stays high until reset

## Operation
- FSM states:
  - INIT: if INIT_CLEAR=1, a counter drives ram_en=1, ram_wmode=1, ram_wdata=0, ram_addr=0..DEPTH-1, one entry per cycle. It then goes to RUN. With INIT_CLEAR=0, the FSM enters RUN on the first cycle after reset.
  - RUN: terminal state; left only by reset.
- All req{i}_ready are 0 in INIT.
- Eligibility in RUN:
  - A write from requester i is always eligible.
  - A read from requester i is eligible only if credit_i > 0.
  - credit_i = 2 − (entries in rsp queue i) − (reads of i in flight).
- Arbitration: round-robin over eligible valid requesters.
  - The priority pointer moves to the other requester after every grant.
  - Pointer reset value is requester 0.
  - Exactly one grant per cycle at most; the loser's req_ready is 0.
- On a grant, the RAM ports are driven combinationally from the granted request: ram_en=1, ram_wmode=req_write, ram_addr, ram_wdata.
- With no grant: ram_en=0, and ram_wmode/ram_addr/ram_wdata hold 0.
- Reads record the owner ID in a one-stage in-flight register. The next cycle, ram_rdata is pushed into the owner's response queue.
- Response queue: 2 entries, FIFO per requester. rsp{i}_valid = queue non-empty. rsp{i}_rdata is the head entry. A pop occurs on valid & ready.
- Credit arithmetic: a pop and a push in the same cycle keep the occupancy count unchanged. Credit never exceeds 2 and never goes negative; an assertion covers both bounds.
- Request channel rules:
  - req{i}_ready may depend combinationally on both req_valid inputs and on credit.
  - Requesters must not make valid depend on ready.
- Ordering:
  - RAM effects follow grant order.
  - A write granted in cycle T is visible to any read granted at T+1 or later.
- Reset (asynchronous, any time, including mid-INIT or with reads in flight):
  - In-flight reads and queued responses are discarded.
  - The FSM returns to INIT and the clear restarts from address 0.

## Timing
- Reset values:
  - init_done=0, all req_ready=0, all rsp_valid=0, rsp_rdata=0.
  - ram_en=0, ram_wmode=0, ram_addr=0, ram_wdata=0.
- INIT lasts DEPTH cycles (64). init_done rises in the first RUN cycle, and req_ready can be high in that same cycle.
- Read latency: granted at edge T → rsp_valid high from T+2 (RAM output in T+1, queue push at end of T+1).
- Throughput: with rsp_ready held high, one requester alone sustains one read per cycle.
  - Credit 2 covers the in-flight plus queued slot.
  - With rsp_ready low, at most 2 reads are accepted; further reads stall, while writes from that requester continue.
- Write: granted at edge T → RAM updated at edge T. There is no response.

## Structure
- Shared package: FSM state enum {INIT, RUN}, requester-ID type, and the DEPTH/ADDR_W/DATA_W defaults.
- One sub-module: rsp_fifo2, a 2-entry FIFO with count output, instantiated once per requester.

## Test plan
- Reset then idle: exactly 64 ram writes of 0 at addresses 0..63; init_done rises in cycle 65; no req_ready before that cycle.
- Write then read: req0 writes 0x2_AAAA_5555_1234 to addr 5, then reads addr 5 → rsp0_rdata = 0x2_AAAA_5555_1234, valid 2 cycles after the read grant.
- Contention: both requesters valid every cycle with reads to addrs 1 and 2 → grants alternate 0,1,0,1; each rsp stream is in order; no starvation.
- Backpressure: rsp1_ready=0 while req1 issues 4 reads → exactly 2 accepted. Raising rsp1_ready drains both in issue order, then the next reads are accepted. Writes from req1 are accepted throughout.
- Reset mid-operation: assert reset_n low with 2 reads in flight/queued → after release, no stale rsp_valid and INIT restarts at addr 0.
- Unwritten readback: with INIT_CLEAR=1, reads of addrs 0, 31, and 63 return 0.
